arm_mac_iter: RTL and testbench

- Parametrised, multi-cycle multiply-accumulate unit; successor to the single-cycle combinational MAC in the execute stage.
- Supports MUL/MLA (short) and UMULL/UMLAL/SMULL/SMLAL (long) with configurable WIDTH and RADIX_BITS multiplier bits retired per cycle.
- Execute stage holds the pipeline while mac_busy is high and writes back on mac_done.

---
 rtl/arm_mac_iter.sv | 175 +++++++++++++++++
 tb/tb_arm_mac_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mac_iter.sv
// Iterative multiply-accumulate unit for MUL/MLA and U/S MULL/MLAL, retiring RADIX_BITS multiplier bits per cycle.
// Optional macro MAC_EARLY_TERM_EN: leave MUL as soon as the remaining multiplier bits are all zero.
module arm_mac_iter #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               mac_start,
  input  logic               mac_flush,
  input  logic [WIDTH-1:0]   mac_op1,
  input  logic [WIDTH-1:0]   mac_op2,
  input  logic [WIDTH-1:0]   mac_acc_lo,
  input  logic [WIDTH-1:0]   mac_acc_hi,
  input  logic               mac_acc_en,
  input  logic               mac_long,
  input  logic               mac_signed,
  input  logic [3:0]         mac_cpsr_in,
  output logic               mac_busy,
  output logic               mac_done,
  output logic [WIDTH-1:0]   mac_out_lo,
  output logic [WIDTH-1:0]   mac_out_hi,
  output logic [3:0]         mac_cpsr
);

  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int DW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r, next_s;
  logic              capture_s, last_step_s, sgn_en_s;
  logic [DW-1:0]     mcand_r, prod_r, acc_r;
  logic [WIDTH-1:0]  op2_rem_r;
  logic [CW-1:0]     cnt_r;
  logic              sign_r, acc_en_r, long_r;
  logic [1:0]        vc_r;
  logic [DW-1:0]     pp_s, prod_fix_s, addend_s, res_s;
  logic              busy_s, done_s;
  logic              busy_r, done_r;
  logic [WIDTH-1:0]  out_lo_r, out_hi_r;
  logic [3:0]        cpsr_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
    if (en && v[WIDTH-1]) magnitude = ~v + WIDTH'(1);
    else                  magnitude = v;
  endfunction

  assign sgn_en_s  = mac_signed & mac_long;
  assign capture_s = mac_start & ~mac_flush & ((state_r == ST_IDLE) | (state_r == ST_DONE));

`ifdef MAC_EARLY_TERM_EN
  assign last_step_s = (cnt_r == CW'(STEPS - 1)) |
                       ((op2_rem_r >> RADIX_BITS) == {WIDTH{1'b0}});
`else
  assign last_step_s = (cnt_r == CW'(STEPS - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_r <= ST_IDLE;
    else        state_r <= next_s;
  end

  // Next-state logic; flush wins over everything, including a simultaneous start
  always_comb begin
    next_s = state_r;
    if (mac_flush) begin
      next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (mac_start)   next_s = ST_MUL; else next_s = ST_IDLE;
        ST_MUL:  if (last_step_s) next_s = ST_FIX; else next_s = ST_MUL;
        ST_FIX:  next_s = ST_DONE;
        ST_DONE: if (mac_start)   next_s = ST_MUL; else next_s = ST_IDLE;
        default: next_s = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so busy/done come straight from flops
  always_comb begin
    busy_s = (next_s == ST_MUL) | (next_s == ST_FIX);
    done_s = (next_s == ST_DONE);
  end

  // Status output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // One radix digit of the multiplier times the shifted multiplicand
  always_comb begin
    pp_s = {DW{1'b0}};
    for (int i = 0; i < RADIX_BITS; i++) begin
      pp_s = pp_s + (op2_rem_r[i] ? (mcand_r << i) : {DW{1'b0}});
    end
  end

  // Sign fix-up and accumulate, evaluated during FIX
  always_comb begin
    prod_fix_s = sign_r ? (~prod_r + DW'(1)) : prod_r;
    if (!acc_en_r)   addend_s = {DW{1'b0}};
    else if (long_r) addend_s = acc_r;
    else             addend_s = {{WIDTH{1'b0}}, acc_r[WIDTH-1:0]};
    res_s = prod_fix_s + addend_s;
  end

  // Operand capture and shift-add datapath
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mcand_r   <= {DW{1'b0}};
      prod_r    <= {DW{1'b0}};
      acc_r     <= {DW{1'b0}};
      op2_rem_r <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      sign_r    <= 1'b0;
      acc_en_r  <= 1'b0;
      long_r    <= 1'b0;
      vc_r      <= 2'b00;
    end else if (capture_s) begin
      mcand_r   <= {{WIDTH{1'b0}}, magnitude(mac_op1, sgn_en_s)};
      op2_rem_r <= magnitude(mac_op2, sgn_en_s);
      prod_r    <= {DW{1'b0}};
      acc_r     <= {mac_acc_hi, mac_acc_lo};
      cnt_r     <= {CW{1'b0}};
      sign_r    <= sgn_en_s & (mac_op1[WIDTH-1] ^ mac_op2[WIDTH-1]);
      acc_en_r  <= mac_acc_en;
      long_r    <= mac_long;
      vc_r      <= mac_cpsr_in[1:0];
    end else if (state_r == ST_MUL) begin
      prod_r    <= prod_r + pp_s;
      mcand_r   <= mcand_r << RADIX_BITS;
      op2_rem_r <= op2_rem_r >> RADIX_BITS;
      cnt_r     <= cnt_r + CW'(1);
    end
  end

  // Result registers: only a completed FIX updates them
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_lo_r <= {WIDTH{1'b0}};
      out_hi_r <= {WIDTH{1'b0}};
      cpsr_r   <= 4'b0000;
    end else if ((state_r == ST_FIX) && !mac_flush) begin
      out_lo_r <= res_s[WIDTH-1:0];
      if (long_r) begin
        out_hi_r <= res_s[DW-1:WIDTH];
        cpsr_r   <= {res_s[DW-1], (res_s == {DW{1'b0}}), vc_r};
      end else begin
        out_hi_r <= {WIDTH{1'b0}};
        cpsr_r   <= {res_s[WIDTH-1], (res_s[WIDTH-1:0] == {WIDTH{1'b0}}), vc_r};
      end
    end
  end

  assign mac_busy   = busy_r;
  assign mac_done   = done_r;
  assign mac_out_lo = out_lo_r;
  assign mac_out_hi = out_hi_r;
  assign mac_cpsr   = cpsr_r;

endmodule

// File: tb/tb_arm_mac_iter.sv
// Scoreboard bench for arm_mac_iter: driver pushes model results, a negedge monitor pops on mac_done.
module tb_arm_mac_iter;
  localparam int W = 32;
  localparam int R = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          mac_start, mac_flush, mac_acc_en, mac_long, mac_signed;
  logic [W-1:0]  mac_op1, mac_op2, mac_acc_lo, mac_acc_hi;
  logic [3:0]    mac_cpsr_in;
  logic          mac_busy, mac_done;
  logic [W-1:0]  mac_out_lo, mac_out_hi;
  logic [3:0]    mac_cpsr;

  arm_mac_iter #(.WIDTH(W), .RADIX_BITS(R)) dut (
    .clk(clk), .rst_b(rst_b), .mac_start(mac_start), .mac_flush(mac_flush),
    .mac_op1(mac_op1), .mac_op2(mac_op2), .mac_acc_lo(mac_acc_lo), .mac_acc_hi(mac_acc_hi),
    .mac_acc_en(mac_acc_en), .mac_long(mac_long), .mac_signed(mac_signed),
    .mac_cpsr_in(mac_cpsr_in), .mac_busy(mac_busy), .mac_done(mac_done),
    .mac_out_lo(mac_out_lo), .mac_out_hi(mac_out_hi), .mac_cpsr(mac_cpsr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   cpsr;
    int           done_at;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operation
  function automatic exp_t model(input logic [W-1:0] a, b, lo, hi, input logic acc_en, lng, sgn,
                                 input logic [3:0] cp);
    exp_t e;
    logic [63:0] p, r;
    longint sa, sb;
    if (lng && sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    r = p + (acc_en ? (lng ? {hi, lo} : {32'd0, lo}) : 64'd0);
    e.lo = r[31:0];
    if (lng) begin
      e.hi = r[63:32];
      e.cpsr = {r[63], (r == 64'd0), cp[1:0]};
    end else begin
      e.hi = 32'd0;
      e.cpsr = {r[31], (r[31:0] == 32'd0), cp[1:0]};
    end
    e.done_at = 0;
    return e;
  endfunction

  function automatic int latency(input logic [W-1:0] b, input logic lng, sgn);
    logic [W-1:0] m;
    int bits, k;
    m = (lng && sgn && b[W-1]) ? (~b + 32'd1) : b;
    bits = 0;
    for (int i = 0; i < W; i++) if (m[i]) bits = i + 1;
`ifdef MAC_EARLY_TERM_EN
    k = (bits + R - 1) / R;
    if (k < 1) k = 1;
`else
    k = W / R;
`endif
    return k + 2;
  endfunction

  // Monitor: every done strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (mac_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_lo", 64'(mac_out_lo), 64'(e.lo));
        check("out_hi", 64'(mac_out_hi), 64'(e.hi));
        check("cpsr", 64'(mac_cpsr), 64'(e.cpsr));
        check("latency", 64'(cyc), 64'(e.done_at));
      end
    end
  end

  // Called at a negedge; scrambles inputs after the capture edge
  task automatic start_op(input logic [W-1:0] a, b, lo, hi, input logic acc_en, lng, sgn,
                          input logic [3:0] cp, input bit push);
    exp_t e;
    mac_op1 = a; mac_op2 = b; mac_acc_lo = lo; mac_acc_hi = hi;
    mac_acc_en = acc_en; mac_long = lng; mac_signed = sgn; mac_cpsr_in = cp;
    mac_start = 1'b1;
    if (push) begin
      e = model(a, b, lo, hi, acc_en, lng, sgn, cp);
      e.done_at = cyc + latency(b, lng, sgn);
      exp_q.push_back(e);
      last_exp = e;
    end
    @(negedge clk);
    mac_start = 1'b0;
    mac_op1 = $urandom; mac_op2 = $urandom; mac_acc_lo = $urandom; mac_acc_hi = $urandom;
    mac_acc_en = 1'($urandom); mac_long = 1'($urandom); mac_signed = 1'($urandom);
    mac_cpsr_in = 4'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!mac_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!mac_done) check("wait_done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_b = 1'b0; mac_start = 1'b0; mac_flush = 1'b0;
    mac_op1 = '0; mac_op2 = '0; mac_acc_lo = '0; mac_acc_hi = '0;
    mac_acc_en = 1'b0; mac_long = 1'b0; mac_signed = 1'b0; mac_cpsr_in = 4'b0000;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(mac_busy), 64'd0);
    check("rst_done", 64'(mac_done), 64'd0);
    check("rst_lo", 64'(mac_out_lo), 64'd0);
    check("rst_hi", 64'(mac_out_hi), 64'd0);
    check("rst_cpsr", 64'(mac_cpsr), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);

    start_op(32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1);
    check("busy_after_start", 64'(mac_busy), 64'd1);
    wait_done();
    start_op(32'h0001_0000, 32'h0001_0000, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    wait_done();
    start_op(32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b1);
    wait_done();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1);
    wait_done();
    start_op(32'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1);
    wait_done();
    @(negedge clk);

    // Flush during MUL: no done, outputs keep the previous result
    start_op(32'h1234_5678, 32'hFFFF_FFFF, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0);
    repeat (3) @(negedge clk);
    mac_flush = 1'b1;
    @(negedge clk);
    mac_flush = 1'b0;
    check("flush_busy", 64'(mac_busy), 64'd0);
    check("flush_done", 64'(mac_done), 64'd0);
    check("flush_lo", 64'(mac_out_lo), 64'(last_exp.lo));
    check("flush_hi", 64'(mac_out_hi), 64'(last_exp.hi));
    check("flush_cpsr", 64'(mac_cpsr), 64'(last_exp.cpsr));
    repeat (25) @(negedge clk);

    // Flush beats a simultaneous start
    mac_start = 1'b1; mac_flush = 1'b1; mac_op2 = 32'd3;
    @(negedge clk);
    mac_start = 1'b0; mac_flush = 1'b0;
    check("flush_vs_start_busy", 64'(mac_busy), 64'd0);
    repeat (25) @(negedge clk);

    start_op(32'd9, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    wait_done();

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 5);
      start_op(rnd_operand(), rnd_operand(), $urandom, $urandom,
               1'(kind % 2), 1'(kind >= 2), (kind >= 4) ? 1'b1 : 1'($urandom), 4'($urandom), 1'b1);
      wait_done();
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Asynchronous reset mid-MUL clears everything at once
    start_op(32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("arst_busy", 64'(mac_busy), 64'd0);
    check("arst_done", 64'(mac_done), 64'd0);
    check("arst_lo", 64'(mac_out_lo), 64'd0);
    check("arst_hi", 64'(mac_out_hi), 64'd0);
    check("arst_cpsr", 64'(mac_cpsr), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (25) @(negedge clk);

    start_op(32'hFFFF_FFF0, 32'h0000_0010, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
